// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
// Shared definitions for the MIPS32 unified-memory arbiter:
//   WORD_W              - data word width (32)
//   RID_DATA/FETCH/HOST - requester IDs reported on rid
//   arb_state_e         - arbiter FSM states (ARB, HOST_LOCK)
//   grant_t             - one bit per requester, used for eligibility and grants
// -----------------------------------------------------------------------------
package mips32_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] RID_DATA  = 2'd0;
  localparam logic [1:0] RID_FETCH = 2'd1;
  localparam logic [1:0] RID_HOST  = 2'd2;

  typedef enum logic {
    ARB       = 1'b0,
    HOST_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic d;  // MEM-stage data port
    logic f;  // IF-stage fetch port
    logic h;  // host/debug port
  } grant_t;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mips32_mem_arbiter_if
// Bundles the three requester ports, the tagged read response and the RAM
// macro port of the memory arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, response, RAM
//            drive out)
//   master : requester/RAM view (the mirror image)
// Parameter ADDR_W: word address width.
// -----------------------------------------------------------------------------
interface mips32_mem_arbiter_if #(
  parameter int ADDR_W = 10
);
  import mips32_pkg::*;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              h_req;
  logic              h_we;
  logic              h_lock;
  logic [ADDR_W-1:0] h_addr;
  logic [WORD_W-1:0] h_wdata;
  logic              halted;

  logic              d_gnt;
  logic              f_gnt;
  logic              h_gnt;
  logic              rvalid;
  logic [1:0]        rid;
  logic [WORD_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, f_req, f_addr,
           h_req, h_we, h_lock, h_addr, h_wdata, halted, mem_rdata,
    output d_gnt, f_gnt, h_gnt, rvalid, rid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata, f_req, f_addr,
           h_req, h_we, h_lock, h_addr, h_wdata, halted, mem_rdata,
    input  d_gnt, f_gnt, h_gnt, rvalid, rid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_arb_prio.sv
// -----------------------------------------------------------------------------
// mips32_arb_prio
// Combinational priority/grant encoder for the memory arbiter.
//   i_elig   - eligible requests (already masked by halt, lock and reset)
//   i_state  - effective arbitration state for this cycle
//   i_starve - host wait counter has reached its limit
//   o_gnt    - one-hot (or zero) grant
// ARB order: starved host, data, fetch, host. HOST_LOCK: host only.
// -----------------------------------------------------------------------------
module mips32_arb_prio
  import mips32_pkg::*;
(
  input  grant_t     i_elig,
  input  arb_state_e i_state,
  input  logic       i_starve,
  output grant_t     o_gnt
);

  always_comb begin
    // NOTE: default every output first so no path through the if-chain can
    // leave it unassigned and infer a latch.
    o_gnt = '0;
    if (i_state == HOST_LOCK) begin
      o_gnt.h = i_elig.h;
    end else if (i_elig.h && i_starve) begin
      o_gnt.h = 1'b1;
    end else if (i_elig.d) begin
      o_gnt.d = 1'b1;
    end else if (i_elig.f) begin
      o_gnt.f = 1'b1;
    end else if (i_elig.h) begin
      o_gnt.h = 1'b1;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips32_mem_arbiter
// Shares one synchronous single-port RAM between the MEM-stage data port,
// the IF-stage fetch port and a host/debug port. Fixed priority with a host
// starvation guard, a host lock mode for bulk loads and tagged read responses.
//   clk  - rising-edge system clock
//   rst  - synchronous reset, active-high
//   bus  - mips32_mem_arbiter_if.slave (requests, grants, response, RAM port)
// Optional build macro MEM_ARB_STATS_EN adds 32-bit wrapping counters
//   stat_d, stat_f, stat_h (grants per port) and stat_conflict (cycles with
//   more than one eligible request).
// -----------------------------------------------------------------------------
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  mips32_mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_d,
  output logic [31:0]         stat_f,
  output logic [31:0]         stat_h,
  output logic [31:0]         stat_conflict
`endif
);

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  arb_state_e        w_arb_state;
  logic [WAIT_W-1:0] r_host_wait;
  logic              w_locked;
  logic              w_starve;
  grant_t            w_elig;
  grant_t            w_gnt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [WORD_W-1:0] w_mem_wdata;
  logic [1:0]        w_rd_id;
  logic              r_rvalid;
  logic [1:0]        r_rid;

  // The lock only holds while h_lock stays high; the cycle it drops is
  // already arbitrated under ARB rules.
  assign w_locked    = (r_state == HOST_LOCK) && bus.h_lock;
  assign w_arb_state = w_locked ? HOST_LOCK : ARB;
  assign w_starve    = (r_host_wait == WAIT_W'(HOST_MAX_WAIT));

  // Reset masks every request so no grant or RAM strobe leaks out while rst=1.
  assign w_elig.d = bus.d_req && !w_locked && !rst;
  assign w_elig.f = bus.f_req && !bus.halted && !w_locked && !rst;
  assign w_elig.h = bus.h_req && !rst;

  mips32_arb_prio u_prio (
    .i_elig   (w_elig),
    .i_state  (w_arb_state),
    .i_starve (w_starve),
    .o_gnt    (w_gnt)
  );

  // FSM: state register and next-state logic.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) r_state <= ARB;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB:       if (w_gnt.h && bus.h_lock) w_state_next = HOST_LOCK;
      HOST_LOCK: if (!bus.h_lock)           w_state_next = ARB;
      default:                              w_state_next = ARB;
    endcase
  end

  // Host starvation counter: counts denied host cycles, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_host_wait <= '0;
    end else if (bus.h_req && !w_gnt.h) begin
      if (!w_starve) r_host_wait <= r_host_wait + WAIT_W'(1);
    end else begin
      r_host_wait <= '0;
    end
  end

  // RAM drive mux from the granted port; all zero when idle.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_rd_id     = RID_DATA;
    if (w_gnt.d) begin
      w_mem_we    = bus.d_we;
      w_mem_addr  = bus.d_addr;
      w_mem_wdata = bus.d_wdata;
      w_rd_id     = RID_DATA;
    end else if (w_gnt.f) begin
      w_mem_addr  = bus.f_addr;
      w_rd_id     = RID_FETCH;
    end else if (w_gnt.h) begin
      w_mem_we    = bus.h_we;
      w_mem_addr  = bus.h_addr;
      w_mem_wdata = bus.h_wdata;
      w_rd_id     = RID_HOST;
    end
  end

  // Read response tag, aligned with the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rid    <= RID_DATA;
    end else begin
      r_rvalid <= (|w_gnt) && !w_mem_we;
      if ((|w_gnt) && !w_mem_we) r_rid <= w_rd_id;
    end
  end

  assign bus.d_gnt     = w_gnt.d;
  assign bus.f_gnt     = w_gnt.f;
  assign bus.h_gnt     = w_gnt.h;
  assign bus.mem_en    = |w_gnt;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  // The response is also forced quiet during rst so a read in flight when
  // reset arrives never surfaces.
  assign bus.rvalid    = r_rvalid && !rst;
  assign bus.rid       = rst ? RID_DATA : r_rid;
  assign bus.rdata     = bus.mem_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_d;
  logic [31:0] r_stat_f;
  logic [31:0] r_stat_h;
  logic [31:0] r_stat_conflict;
  logic        w_conflict;

  assign w_conflict = (w_elig.d && w_elig.f) || (w_elig.d && w_elig.h) ||
                      (w_elig.f && w_elig.h);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_d        <= '0;
      r_stat_f        <= '0;
      r_stat_h        <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (w_gnt.d)    r_stat_d        <= r_stat_d + 32'd1;
      if (w_gnt.f)    r_stat_f        <= r_stat_f + 32'd1;
      if (w_gnt.h)    r_stat_h        <= r_stat_h + 32'd1;
      if (w_conflict) r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end

  assign stat_d        = r_stat_d;
  assign stat_f        = r_stat_f;
  assign stat_h        = r_stat_h;
  assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips32_mem_arbiter
// Self-checking bench for mips32_mem_arbiter. The bench plays the three
// requesters and the RAM macro. A behavioural model (winner selection from
// the priority rules, a wait count, a lock flag and a shadow memory) predicts
// grants, RAM drive and read responses every cycle. Directed scenarios come
// first, then a randomized phase with handshake-respecting requesters.
// -----------------------------------------------------------------------------
module tb_mips32_mem_arbiter;
  import mips32_pkg::*;

  localparam int ADDR_W = 10;
  localparam int HMW    = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips32_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_d, stat_f, stat_h, stat_conflict;
`endif

  mips32_mem_arbiter #(.ADDR_W(ADDR_W), .HOST_MAX_WAIT(HMW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_d        (stat_d),
    .stat_f        (stat_f),
    .stat_h        (stat_h),
    .stat_conflict (stat_conflict)
`endif
  );

  // RAM macro: synchronous single port, one-cycle read latency.
  logic [31:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // Reference model state.
  bit          m_locked;
  int          m_wait;
  bit          m_rv;
  int          m_rid;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] m_sd, m_sf, m_sh, m_sc;
  int          last_own;
  logic [2:0]  obs_gnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner for the current inputs: -1 none, 0 data, 1 fetch, 2 host.
  function automatic int exp_owner();
    bit lk, ed, ef, eh;
    if (rst) return -1;
    lk = m_locked && bus.h_lock;
    ed = bus.d_req && !lk;
    ef = bus.f_req && !bus.halted && !lk;
    eh = bus.h_req;
    if (eh && m_wait == HMW) return 2;
    if (ed) return 0;
    if (ef) return 1;
    if (eh) return 2;
    return -1;
  endfunction

  // One clock cycle: check outputs at the falling edge, advance the model at
  // the rising edge, return 1 time unit later so stimulus can change.
  task automatic cycle();
    int                own;
    int                n_elig;
    bit                lk;
    logic [2:0]        eg;
    logic              ewe;
    logic [ADDR_W-1:0] ea;
    logic [31:0]       ew;
    @(negedge clk);
    own = exp_owner();
    eg  = (own == 0) ? 3'b100 : (own == 1) ? 3'b010 : (own == 2) ? 3'b001 : 3'b000;
    ewe = (own == 0) ? bus.d_we : (own == 2) ? bus.h_we : 1'b0;
    ea  = (own == 0) ? bus.d_addr : (own == 1) ? bus.f_addr : bus.h_addr;
    ew  = (own == 0) ? bus.d_wdata : bus.h_wdata;
    obs_gnt = {bus.d_gnt, bus.f_gnt, bus.h_gnt};
    check("gnt", obs_gnt, eg);
    check("mem_en", bus.mem_en, own >= 0);
    check("mem_we", bus.mem_we, ewe);
    if (own >= 0) check("mem_addr", bus.mem_addr, ea);
    if (ewe) check("mem_wdata", bus.mem_wdata, ew);
    check("rvalid", bus.rvalid, m_rv && !rst);
    if (m_rv && !rst) begin
      check("rid", bus.rid, m_rid);
      check("rdata", bus.rdata, m_rdata);
    end
`ifdef MEM_ARB_STATS_EN
    check("stat_d", stat_d, m_sd);
    check("stat_f", stat_f, m_sf);
    check("stat_h", stat_h, m_sh);
    check("stat_conflict", stat_conflict, m_sc);
`endif
    last_own = own;
    @(posedge clk);
    if (rst) begin
      m_locked = 0; m_wait = 0; m_rv = 0;
      m_sd = 0; m_sf = 0; m_sh = 0; m_sc = 0;
    end else begin
      lk = m_locked && bus.h_lock;
      n_elig = int'(bus.d_req && !lk) + int'(bus.f_req && !bus.halted && !lk) + int'(bus.h_req);
      if (n_elig > 1) m_sc++;
      if (own == 0) m_sd++;
      if (own == 1) m_sf++;
      if (own == 2) m_sh++;
      m_rv = (own >= 0) && !ewe;
      if (m_rv) begin
        m_rid   = own;
        m_rdata = ref_mem[ea];
      end
      if (own >= 0 && ewe) ref_mem[ea] = ew;
      m_wait   = (bus.h_req && own != 2) ? ((m_wait < HMW) ? m_wait + 1 : HMW) : 0;
      m_locked = lk || (own == 2 && bus.h_lock);
    end
    #1;
  endtask

  initial begin
    int k;
    int fg;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    m_locked = 0; m_wait = 0; m_rv = 0; m_rid = 0; m_rdata = '0;
    m_sd = 0; m_sf = 0; m_sh = 0; m_sc = 0; last_own = -1;
    rst = 1'b1;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.f_req = 0; bus.f_addr = '0;
    bus.h_req = 0; bus.h_we = 0; bus.h_lock = 0; bus.h_addr = '0; bus.h_wdata = '0;
    bus.halted = 0; bus.mem_rdata = '0;

    // Reset, with requests present to show they are masked.
    bus.d_req = 1; bus.f_req = 1; bus.h_req = 1;
    cycle();
    cycle();
    check("rst_gnt", obs_gnt, 3'b000);
    check("rst_rid", bus.rid, 2'd0);
    bus.d_req = 0; bus.f_req = 0; bus.h_req = 0;
    rst = 1'b0;
    cycle();

    // Host writes 7 to 200, data port reads it back.
    bus.h_req = 1; bus.h_we = 1; bus.h_addr = 10'd200; bus.h_wdata = 32'd7;
    cycle();
    bus.h_req = 0; bus.h_we = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd200;
    cycle();
    check("rd200_gnt", obs_gnt, 3'b100);
    bus.d_req = 0;
    check("rd200_rvalid", bus.rvalid, 1'b1);
    check("rd200_rid", bus.rid, RID_DATA);
    check("rd200_rdata", bus.rdata, 32'd7);
    cycle();

    // Data and fetch collide: data first, fetch next cycle.
    bus.d_req = 1; bus.d_addr = 10'd200; bus.f_req = 1; bus.f_addr = 10'd201;
    cycle();
    check("conf_first", obs_gnt, 3'b100);
    bus.d_req = 0;
    cycle();
    check("conf_second", obs_gnt, 3'b010);
    check("conf_rid0", bus.rid, RID_FETCH);
    bus.f_req = 0;
    cycle();

    // Starvation guard under continuous data traffic.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd1;
    bus.h_req = 1; bus.h_we = 0; bus.h_addr = 10'd200;
    k = -1;
    for (int i = 0; i < HMW + 4 && k < 0; i++) begin
      cycle();
      if (obs_gnt[0]) k = i;
    end
    check("starve_latency", k, HMW);
    bus.h_req = 0;
    cycle();
    check("starve_resume", obs_gnt, 3'b100);
    bus.d_req = 0;
    cycle();

    // Host lock: bulk writes to 0..10, fetch locked out until h_lock drops.
    bus.h_req = 1; bus.h_we = 1; bus.h_lock = 1; bus.h_addr = 10'd0; bus.h_wdata = 32'h100;
    cycle();
    bus.f_req = 1; bus.f_addr = 10'd9;
    fg = 0;
    for (int a = 1; a <= 10; a++) begin
      bus.h_addr = 10'(a); bus.h_wdata = 32'h100 + 32'(a);
      cycle();
      fg += int'(obs_gnt[1]);
    end
    check("lock_no_fetch", fg, 0);
    bus.h_lock = 0; bus.h_req = 0; bus.h_we = 0;
    cycle();
    check("unlock_fetch", obs_gnt, 3'b010);
    bus.f_req = 0;
    check("unlock_rdata", bus.rdata, 32'h109);
    cycle();

    // Halt masking.
    bus.halted = 1; bus.f_req = 1; bus.f_addr = 10'd4;
    cycle();
    check("halt_nognt", obs_gnt, 3'b000);
    bus.halted = 0;
    cycle();
    check("unhalt_fetch", obs_gnt, 3'b010);
    bus.f_req = 0;
    cycle();

    // Reset in the cycle after a granted read.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd5;
    cycle();
    bus.d_req = 0;
    rst = 1;
    cycle();
    check("rstmid_rvalid", bus.rvalid, 1'b0);
`ifdef MEM_ARB_STATS_EN
    check("rstmid_stat_d", stat_d, 32'd0);
    check("rstmid_stat_f", stat_f, 32'd0);
    check("rstmid_stat_h", stat_h, 32'd0);
    check("rstmid_stat_conflict", stat_conflict, 32'd0);
`endif
    rst = 0;
    cycle();
    check("rstmid_gnt", obs_gnt, 3'b000);

    // Randomized traffic with requesters that hold until granted.
    for (int i = 0; i < 600; i++) begin
      if (!bus.d_req || last_own == 0) begin
        bus.d_req   = ($urandom_range(0, 99) < 45);
        bus.d_we    = $urandom_range(0, 1);
        bus.d_addr  = 10'($urandom_range(0, 15));
        bus.d_wdata = $urandom;
      end
      if (!bus.f_req || last_own == 1) begin
        bus.f_req  = ($urandom_range(0, 99) < 45);
        bus.f_addr = 10'($urandom_range(0, 15));
      end
      if (!bus.h_req || last_own == 2) begin
        bus.h_req   = ($urandom_range(0, 99) < 30);
        bus.h_we    = $urandom_range(0, 1);
        bus.h_addr  = 10'($urandom_range(0, 15));
        bus.h_wdata = $urandom;
        if ($urandom_range(0, 7) == 0) bus.h_lock = ~bus.h_lock;
      end
      if ($urandom_range(0, 9) == 0) bus.halted = ~bus.halted;
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Single-port memory arbiter for the pipelined MIPS32 core's unified instruction/data memory. Shares one synchronous single-port RAM between three requesters: the MEM-stage data port (LW/SW), the IF-stage fetch port, and a host/debug port used to preload programs and read results. Sits between the core pipeline, the host interface and the RAM macro. Provides fixed priority, a host starvation guard, a host lock mode for bulk loads, and tagged read responses.

## Interface
- ADDR_W, 10, word address width; RAM depth is 2**ADDR_W words.
- HOST_MAX_WAIT, 8, number of consecutive denied host-request cycles before the host is forced to win.
- clk  in  1  single system clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- d_req, d_we  in  1 each  data-port request and write enable.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  data write value.
- f_req  in  1  fetch request, read only.
- f_addr  in  ADDR_W  fetch word address.
- h_req, h_we  in  1 each  host request and write enable.
- h_lock  in  1  host requests exclusive ownership.
- h_addr  in  ADDR_W  host address.
- h_wdata  in  32  host write value.
- halted  in  1  core HALTED flag; masks fetch requests.
- d_gnt, f_gnt, h_gnt  out  1 each  one-hot grant, issued the same cycle as the access.
- rvalid  out  1  read data valid.
- rid  out  2  owner of rdata: 0 = data, 1 = fetch, 2 = host.
- rdata  out  32  read data, driven from mem_rdata.
- mem_en, mem_we  out  1 each  RAM enable and write strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid 1 cycle after mem_en with !mem_we.

## Operation
- Request/grant handshake: a requester holds req, addr, we and wdata stable until it sees gnt. A request is complete in the cycle gnt=1. At most one gnt per cycle.
- Fetch is masked: it is treated as f_req=0 while halted=1.
- States:
  - ARB (reset state).
  - HOST_LOCK.
- ARB priority:
  1. Host, if host_wait == HOST_MAX_WAIT.
  2. Data.
  3. Fetch.
  4. Host.
- host_wait counter:
  - Increments each cycle h_req=1 and h_gnt=0, saturating at HOST_MAX_WAIT.
  - Clears on h_gnt or when h_req=0.
- ARB -> HOST_LOCK: in the cycle h_gnt=1 and h_lock=1.
- In HOST_LOCK:
  - Only the host is granted. d_gnt and f_gnt are held at 0, and the core stalls on its own missing grants.
  - HOST_LOCK -> ARB in the cycle h_lock=0. The arbitration in that same cycle uses ARB rules.
- Memory drive:
  - mem_en = any gnt.
  - mem_we = the granted port's we; fetch is always 0.
  - mem_addr and mem_wdata come from the granted port.
  - With no grant: mem_en=0, mem_we=0, and addr/wdata are 0.
- Read response: a granted read registers rvalid=1 and rid=the owner for the next cycle. Writes produce no response.
- Addresses are ADDR_W bits and never checked. Callers truncate, so wrap-around is the caller's concern.

## Timing
- Grants are combinational from the current requests and registered state; there is no bubble between back-to-back grants.
- Read latency is 1 cycle: gnt in cycle N gives rvalid/rid/rdata in cycle N+1.
- Throughput is one access per cycle.
- Reset values (also held in every cycle rst=1):
  - All gnt = 0, rvalid = 0, rid = 0.
  - mem_en = 0, mem_we = 0.
  - State = ARB, host_wait = 0.
- Reset mid-operation: an in-flight read response is dropped (rvalid=0 in the cycle after the rst cycle), and a held lock is released.
- Simultaneous d_req and f_req in ARB: data wins and fetch retries the next cycle.
- Starvation guard: h_req is granted within HOST_MAX_WAIT+1 cycles of assertion, even under continuous d_req.

## Configuration
- MEM_ARB_STATS_EN defined: adds outputs:
  - stat_d, stat_f, stat_h (32-bit each): per-port grant counters.
  - stat_conflict (32-bit): counts cycles with more than one eligible request.
  - All counters wrap at 2**32, reset to 0, and are cleared by rst.
- MEM_ARB_STATS_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package mips32_pkg holds:
  - Requester ID localparams RID_DATA=0, RID_FETCH=1, RID_HOST=2.
  - The arbiter state enum (ARB, HOST_LOCK).
  - WORD_W=32.
- One sub-module, mips32_arb_prio: the combinational priority/grant encoder, with inputs the eligible requests, state and starve flag, and output the one-hot grant.
- The counter, FSM and response register live in the top module.

## Test plan
- Read after reset: write h_addr=200 with 7; then d_req read at 200 -> d_gnt the same cycle; next cycle rvalid=1, rid=0, rdata=7.
- Conflict: d_req and f_req together on cycle N -> d_gnt at N, f_gnt at N+1, rid sequence 0 then 1.
- Starvation: hold d_req continuously with h_req asserted, HOST_MAX_WAIT=8 -> h_gnt exactly 8 cycles later, for one cycle, then d_gnt resumes.
- Host lock: h_lock=1 with 11 consecutive writes to 0..10 while f_req=1 -> f_gnt=0 throughout; f_gnt=1 in the cycle h_lock drops.
- Halt masking: halted=1 with f_req=1 -> no grant and mem_en=0; halted=0 -> f_gnt=1 the same cycle.
- Reset mid-read: rst=1 in the cycle after a granted read -> rvalid=0, state ARB, all gnt=0; with MEM_ARB_STATS_EN defined, all stat_* = 0.
